// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sequences FETCH/PUSH/POP/JUMP strobes for the PC/SP/memory block and tracks stack depth
module mem_access_sequencer #(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [1:0]         op,
  input  logic [1:0]         src_sel,
  input  logic               jmp_sel,
  output logic               busy,
  output logic               done,
  output logic               pop_valid,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic               PCWrite,
  output logic               SPWrite,
  output logic               InstWrite,
  output logic               MemWrite,
  output logic [2:0]         PCSrc,
  output logic [2:0]         SPSrc,
  output logic [1:0]         MemSrc,
  output logic [2:0]         MemDst
);
  typedef enum logic [3:0] {INIT, IDLE, FETCH, INCPC, PUSH_WR, PUSH_SP, POP_SP, POP_RD, JUMP, ERR} state_t;
  state_t state, nxt;
  logic [1:0] src_q;
  logic jmp_q;
  logic full, empty;
  assign full  = depth == DEPTH_W'(STACK_DEPTH);
  assign empty = depth == '0;
  // state register; reset parks the sequencer in INIT mid-operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else state <= nxt;
  end
  // operand latch on acceptance and stack occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      jmp_q <= 1'b0;
      depth <= '0;
    end else begin
      if (state == IDLE && req) begin
        src_q <= src_sel;
        jmp_q <= jmp_sel;
      end
      if (state == PUSH_SP) depth <= depth + DEPTH_W'(1);
      else if (state == POP_SP) depth <= depth - DEPTH_W'(1);
    end
  end
  // next-state selection and per-state strobes; outputs held quiet while reset is asserted
  always_comb begin
    nxt       = IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    pop_valid = 1'b0;
    err       = 1'b0;
    PCWrite   = 1'b0;
    SPWrite   = 1'b0;
    InstWrite = 1'b0;
    MemWrite  = 1'b0;
    PCSrc     = 3'd0;
    SPSrc     = 3'd0;
    MemSrc    = 2'd0;
    MemDst    = 3'd0;
    case (state)
      IDLE:    nxt = !req ? IDLE :
                     op == 2'd0 ? FETCH :
                     op == 2'd1 ? (full ? ERR : PUSH_WR) :
                     op == 2'd2 ? (empty ? ERR : POP_SP) : JUMP;
      FETCH:   nxt = INCPC;
      PUSH_WR: nxt = PUSH_SP;
      POP_SP:  nxt = POP_RD;
      default: nxt = IDLE;
    endcase
    if (rst_n) begin
      busy = state != INIT && state != IDLE;
      case (state)
        INIT: begin
          PCWrite = 1'b1;
          PCSrc   = 3'd2;
        end
        FETCH:   InstWrite = 1'b1;
        INCPC: begin
          PCWrite = 1'b1;
          done    = 1'b1;
        end
        PUSH_WR: begin
          MemWrite = 1'b1;
          MemDst   = 3'd2;
          MemSrc   = src_q;
        end
        PUSH_SP: begin
          SPWrite = 1'b1;
          SPSrc   = 3'd1;
          done    = 1'b1;
        end
        POP_SP: begin
          SPWrite = 1'b1;
          SPSrc   = 3'd2;
        end
        POP_RD: begin
          MemDst    = 3'd2;
          pop_valid = 1'b1;
          done      = 1'b1;
        end
        JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = jmp_q ? 3'd3 : 3'd1;
          done    = 1'b1;
        end
        ERR: begin
          err  = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: operation-level model plus a small PC/SP/memory environment checking the sequencer every cycle
module tb_mem_access_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, jmp_sel = 1'b0;
  logic [1:0] op = 2'd0, src_sel = 2'd0;
  logic busy, done, pop_valid, err, PCWrite, SPWrite, InstWrite, MemWrite;
  logic [4:0] depth;
  logic [2:0] PCSrc, SPSrc, MemDst;
  logic [1:0] MemSrc;
  typedef struct packed {
    logic busy, done, pop_valid, err, pcw, spw, iw, mw;
    logic [2:0] pcs, sps;
    logic [1:0] ms;
    logic [2:0] md;
    logic [4:0] dep;
    logic [15:0] val;
  } ov_t;
  ov_t exp_q[$], pend[$];
  logic [15:0] stk[$];
  int m_depth = 0, n_cmp = 0, n_bad = 0;
  logic [15:0] pc = 16'hbeef, sp = 16'h0, last_pop = 16'h0, sp_b;
  logic [15:0] mem [64];
  always #5 clk = ~clk;
  mem_access_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .src_sel(src_sel), .jmp_sel(jmp_sel),
    .busy(busy), .done(done), .pop_valid(pop_valid), .err(err), .depth(depth),
    .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite), .MemWrite(MemWrite),
    .PCSrc(PCSrc), .SPSrc(SPSrc), .MemSrc(MemSrc), .MemDst(MemDst)
  );
  function automatic logic [15:0] srcd(input logic [1:0] s);
    return s == 2'd0 ? 16'd100 : s == 2'd1 ? 16'h1111 : s == 2'd2 ? 16'h2222 : 16'h3333;
  endfunction
  // environment datapath reacting to the strobes
  always @(posedge clk) begin
    if (PCWrite) pc <= PCSrc == 3'd0 ? pc + 16'd2 : PCSrc == 3'd1 ? 16'h0123 : PCSrc == 3'd3 ? 16'h0040 : 16'h0000;
    if (SPWrite) sp <= SPSrc == 3'd1 ? sp + 16'd2 : SPSrc == 3'd2 ? sp - 16'd2 : sp;
    if (MemWrite && MemDst == 3'd2) mem[sp[6:1]] <= srcd(MemSrc);
    if (pop_valid) last_pop <= mem[sp[6:1]];
  end
  // per-cycle comparison against the model's expected output trace
  always @(negedge clk) begin
    ov_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {busy, done, pop_valid, err, PCWrite, SPWrite, InstWrite, MemWrite, PCSrc, SPSrc, MemSrc, MemDst, depth,
           pop_valid ? mem[sp[6:1]] : 16'h0000};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] rq);
    n_cmp++;
    if (act !== rq) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, rq);
    end
  endtask
  function automatic ov_t zv(input int d);
    ov_t v = '0;
    v.dep = 5'(d);
    return v;
  endfunction
  task automatic plan(input logic [1:0] o, input logic [1:0] s, input logic j);
    ov_t a, b;
    a = zv(m_depth);
    a.busy = 1'b1;
    b = a;
    case (o)
      2'd0: begin
        a.iw = 1'b1;
        b.pcw = 1'b1; b.done = 1'b1;
        pend.push_back(a); pend.push_back(b);
      end
      2'd1: if (m_depth == 16) begin
        a.err = 1'b1; a.done = 1'b1;
        pend.push_back(a);
      end else begin
        a.mw = 1'b1; a.md = 3'd2; a.ms = s;
        b.spw = 1'b1; b.sps = 3'd1; b.done = 1'b1;
        pend.push_back(a); pend.push_back(b);
        stk.push_back(srcd(s));
        m_depth++;
      end
      2'd2: if (m_depth == 0) begin
        a.err = 1'b1; a.done = 1'b1;
        pend.push_back(a);
      end else begin
        a.spw = 1'b1; a.sps = 3'd2;
        b.md = 3'd2; b.pop_valid = 1'b1; b.done = 1'b1; b.dep = 5'(m_depth - 1); b.val = stk.pop_back();
        pend.push_back(a); pend.push_back(b);
        m_depth--;
      end
      default: begin
        a.pcw = 1'b1; a.pcs = j ? 3'd3 : 3'd1; a.done = 1'b1;
        pend.push_back(a);
      end
    endcase
  endtask
  task automatic tick(input logic r, input logic [1:0] o, input logic [1:0] s, input logic j);
    req = r; op = o; src_sel = s; jmp_sel = j;
    if (pend.size() == 0) begin
      exp_q.push_back(zv(m_depth));
      if (r) plan(o, s, j);
    end else exp_q.push_back(pend.pop_front());
    @(posedge clk); #1;
  endtask
  task automatic rtick();
    rst_n = 1'b0; req = 1'b0;
    pend.delete(); stk.delete(); m_depth = 0;
    exp_q.push_back(zv(0));
    @(posedge clk); #1;
  endtask
  task automatic rel();
    ov_t v;
    rst_n = 1'b1;
    v = zv(0); v.pcw = 1'b1; v.pcs = 3'd2;
    exp_q.push_back(v);
    @(posedge clk); #1;
  endtask
  initial begin
    @(posedge clk); #1;
    rtick(); rtick(); rel();
    chk("init_pc", pc, 16'h0000);
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("push_sp", sp, 16'd2);
    chk("push_depth", 16'(depth), 16'd1);
    tick(1, 2, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("pop_sp", sp, 16'd0);
    chk("pop_data", last_pop, 16'd100);
    tick(1, 2, 0, 0); tick(0, 0, 0, 0);
    chk("empty_pop_sp", sp, 16'd0);
    for (int i = 0; i < 16; i++) begin
      tick(1, 1, 2'(i), 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    end
    tick(1, 1, 0, 0); tick(0, 0, 0, 0);
    chk("full_depth", 16'(depth), 16'd16);
    chk("full_sp", sp, 16'd32);
    repeat (6) tick(1, 2, 0, 0);
    tick(0, 0, 0, 0);
    chk("held_pop_data", last_pop, 16'h2222);
    chk("held_pop_sp", sp, 16'd28);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("fetch_pc", pc, 16'h0002);
    tick(1, 3, 0, 1); tick(0, 0, 0, 0);
    chk("jump_imm_pc", pc, 16'h0040);
    tick(1, 3, 0, 0); tick(0, 0, 0, 0);
    chk("jump_comp_pc", pc, 16'h0123);
    sp_b = sp;
    tick(1, 1, 1, 0); tick(0, 0, 0, 0);
    rtick(); rtick(); rel();
    chk("reset_depth", 16'(depth), 16'd0);
    chk("reset_sp", sp, sp_b);
    tick(0, 0, 0, 0);
    tick(1, 1, 2, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("resume_depth", 16'(depth), 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 16, maximum number of 16-bit words the stack may hold.
REQ-002 Parameter DEPTH_W, default 5, width of the depth counter; it SHALL satisfy 2^DEPTH_W > STACK_DEPTH.
REQ-003 clock  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  operation request, sampled only in IDLE.
REQ-006 op  in  2  00 FETCH, 01 PUSH, 10 POP, 11 JUMP.
REQ-007 src_sel  in  2  PUSH data source, copied to MemSrc: 0 Mary, 1 Shelley, 2 RA, 3 Comp.
REQ-008 jmp_sel  in  1  JUMP target: 0 CompData (PCSrc=1), 1 ls_imm (PCSrc=3).
REQ-009 busy  out  1  high from the cycle after acceptance through the done cycle.
REQ-010 done  out  1  one-cycle pulse in the final state of each operation.
REQ-011 pop_valid  out  1  one-cycle pulse; MemVal_out holds the popped word in this cycle.
REQ-012 err  out  1  one-cycle pulse on a rejected PUSH (full) or POP (empty).
REQ-013 depth  out  DEPTH_W  current stack occupancy.
REQ-014 PCWrite, SPWrite, InstWrite, MemWrite  out  1 each  write strobes to the PC/SP/memory block.
REQ-015 PCSrc  out  3  0 PC+2, 1 CompData, 2 zero, 3 ls_imm.
REQ-016 SPSrc  out  3  0 hold, 1 SP+2, 2 SP-2.
REQ-017 MemSrc  out  2  write-data select per REQ-007.
REQ-018 MemDst  out  3  0 PC, 1 ze_imm, 2 SP; codes 3-7 are never driven.

Function
REQ-019 States SHALL be INIT, IDLE, FETCH, INCPC, PUSH_WR, PUSH_SP, POP_SP, POP_RD, JUMP, ERR.
REQ-020 INIT SHALL last exactly one cycle after reset deasserts, driving PCWrite=1 and PCSrc=2 (PC <- 0), then go to IDLE.
REQ-021 In IDLE with req=1, the op SHALL be latched and the next state chosen by op; req while busy SHALL be ignored.
REQ-022 FETCH: InstWrite=1, MemDst=0; then INCPC: PCWrite=1, PCSrc=0, done=1.
REQ-023 PUSH, depth<STACK_DEPTH: PUSH_WR drives MemWrite=1, MemDst=2, MemSrc=latched src_sel; PUSH_SP drives SPWrite=1, SPSrc=1, done=1; depth SHALL increment at the end of PUSH_SP.
REQ-024 POP, depth>0: POP_SP drives SPWrite=1, SPSrc=2; POP_RD drives MemDst=2, pop_valid=1, done=1; depth SHALL decrement at the end of POP_SP.
REQ-025 JUMP: a single state driving PCWrite=1, PCSrc=1 or 3 per latched jmp_sel, done=1.
REQ-026 PUSH at depth=STACK_DEPTH or POP at depth=0 SHALL go to ERR: err=1, done=1, all strobes 0, depth and SP unchanged.
REQ-027 Every operation state SHALL return to IDLE; a req held high SHALL be re-accepted in that IDLE cycle, giving at most one idle cycle between operations.
REQ-028 Outside the states listed, all strobes SHALL be 0 and the select outputs SHALL be 0.
REQ-029 Latency from acceptance to done: FETCH/PUSH/POP 2 cycles, JUMP/ERR 1 cycle.

Reset
REQ-030 reset=0 SHALL force INIT immediately, including mid-operation.
REQ-031 While reset=0: depth=0, busy/done/err/pop_valid=0, all strobes 0, selects 0.
REQ-032 An operation interrupted by reset SHALL NOT complete, and no strobe SHALL be emitted after reset asserts.

Verification
REQ-033 Release reset: INIT with PCWrite=1, PCSrc=2 for 1 cycle, then IDLE, depth=0.
REQ-034 PUSH, src_sel=0, MaryData=100: MemWrite cycle at MemDst=2, then SPWrite/SPSrc=1; sp_out=2, depth=1, done once.
REQ-035 Then POP: SPSrc=2 cycle, then pop_valid with MemVal_out=100; sp_out=0, depth=0.
REQ-036 POP at depth=0: err=1, done=1, no SPWrite; 16 PUSHes, then a 17th: err=1, depth stays 16.
REQ-037 FETCH, then JUMP with jmp_sel=1, ls_imm=0x0040: InstWrite cycle, PC+2 cycle, then pc_out=0x0040.
REQ-038 Assert reset during PUSH_WR: no PUSH_SP strobe follows; after release, INIT, depth=0.
